// File: rtl/ssd_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_arbiter_if
// Description : Bundles the requester-side and pin-side signals of the
//               seven-segment display arbiter.
//               master : requesters / board side (drives requests, data,
//                        enables; observes grants, frame_done and pins)
//               slave  : the arbiter itself
//   game_req, game_data[31:0]  game requester level request and hex word
//   dbg_req,  dbg_data[31:0]   debug requester level request and hex word
//   digit_en[7:0], dp_mask[7:0] per-digit enable / decimal point
//   grant_game, grant_dbg      which requester owns the current frame
//   frame_done                 one-cycle pulse on the last frame cycle
//   an[7:0], seg[6:0], dp      active-low display pins
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_scan_arbiter_if;
  logic        game_req;
  logic [31:0] game_data;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        grant_game;
  logic        grant_dbg;
  logic        frame_done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output game_req, game_data, dbg_req, dbg_data, digit_en, dp_mask,
    input  grant_game, grant_dbg, frame_done, an, seg, dp
  );

  modport slave (
    input  game_req, game_data, dbg_req, dbg_data, digit_en, dp_mask,
    output grant_game, grant_dbg, frame_done, an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_arbiter
// Description : Owns the 8-digit seven-segment display. At each frame
//               boundary it picks debug over game, latches the winner's
//               32-bit hex word plus digit enables and decimal points into
//               shadow registers, then scans the digits with a fixed slot
//               length and a blanking interval at the start of each slot.
// Ports       : clk  - system clock
//               rst  - asynchronous, active-high reset
//               bus  - ssd_scan_arbiter_if.slave (requests, data, pins)
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_arbiter #(
  parameter int TICK_BITS    = 18,
  parameter int BLANK_CYCLES = 1024
) (
  input  wire                  clk,
  input  wire                  rst,
  ssd_scan_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // With no blanking, a slot starts directly in DRIVE.
  localparam state_t               c_slot_start = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
  localparam logic [TICK_BITS-1:0] c_cnt_last   = '1;
  localparam logic [TICK_BITS-1:0] c_blank_last =
    TICK_BITS'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_t               r_state;
  logic [2:0]           r_digit;
  logic [TICK_BITS-1:0] r_cnt;
  logic [31:0]          r_shadow_data;
  logic [7:0]           r_shadow_en;
  logic [7:0]           r_shadow_dp;
  logic                 r_grant_game;
  logic                 r_grant_dbg;
  logic                 r_frame_done;
  logic [7:0]           r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  state_t               w_state_nxt;
  logic [2:0]           w_digit_nxt;
  logic [TICK_BITS-1:0] w_cnt_nxt;
  logic [7:0]           w_an_nxt;
  logic [6:0]           w_seg_nxt;
  logic                 w_dp_nxt;
  logic                 w_frame_done_nxt;
  logic [3:0]           w_nibble;
  logic [6:0]           w_seg_dec;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_digit <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Hex decode of the current digit's shadow nibble (abcdefg, active low)
  // --------------------------------------------------------------------------
  assign w_nibble = r_shadow_data[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nibble)
      4'h0: w_seg_dec = 7'b0000001;
      4'h1: w_seg_dec = 7'b1001111;
      4'h2: w_seg_dec = 7'b0010010;
      4'h3: w_seg_dec = 7'b0000110;
      4'h4: w_seg_dec = 7'b1001100;
      4'h5: w_seg_dec = 7'b0100100;
      4'h6: w_seg_dec = 7'b0100000;
      4'h7: w_seg_dec = 7'b0001111;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0000100;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b1100000;
      4'hC: w_seg_dec = 7'b0110001;
      4'hD: w_seg_dec = 7'b1000010;
      4'hE: w_seg_dec = 7'b0110000;
      4'hF: w_seg_dec = 7'b0111000;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next state and next pin values. The slot counter runs straight through
  // BLANK and DRIVE so one slot is always 2^TICK_BITS cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_digit_nxt      = r_digit;
    w_cnt_nxt        = r_cnt + 1'b1;
    w_an_nxt         = 8'hFF;
    w_seg_nxt        = 7'h7F;
    w_dp_nxt         = 1'b1;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      ST_LOAD: begin
        w_digit_nxt = 3'd0;
        w_cnt_nxt   = '0;
        w_state_nxt = c_slot_start;
      end

      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        w_seg_nxt = w_seg_dec;
        if (r_shadow_en[r_digit]) begin
          w_an_nxt = ~(8'd1 << r_digit);
          w_dp_nxt = ~r_shadow_dp[r_digit];
        end
        if (r_cnt == c_cnt_last) begin
          if (r_digit == 3'd7) begin
            w_state_nxt      = ST_LOAD;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_digit_nxt = r_digit + 1'b1;
            w_state_nxt = c_slot_start;
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOAD;
        w_digit_nxt = 3'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame-boundary arbitration and shadow capture. With no requester the
  // previous image is kept, but enables and decimal points still refresh.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_data <= 32'd0;
      r_shadow_en   <= 8'd0;
      r_shadow_dp   <= 8'd0;
      r_grant_game  <= 1'b0;
      r_grant_dbg   <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_shadow_en <= bus.digit_en;
      r_shadow_dp <= bus.dp_mask;
      if (bus.dbg_req) begin
        r_shadow_data <= bus.dbg_data;
        r_grant_dbg   <= 1'b1;
        r_grant_game  <= 1'b0;
      end else if (bus.game_req) begin
        r_shadow_data <= bus.game_data;
        r_grant_dbg   <= 1'b0;
        r_grant_game  <= 1'b1;
      end else begin
        r_grant_dbg   <= 1'b0;
        r_grant_game  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered pins
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= 8'hFF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.grant_game = r_grant_game;
  assign bus.grant_dbg  = r_grant_dbg;
  assign bus.frame_done = r_frame_done;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_arbiter
// Description : Self-checking bench for ssd_scan_arbiter with TICK_BITS=4,
//               BLANK_CYCLES=2 (16-cycle slot, 129-cycle frame). A cycle
//               model derived from the frame arithmetic checks every pin on
//               every clock; a vector table and hand sequences probe the
//               documented corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_arbiter;
  localparam int c_frame = 129;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ssd_scan_arbiter_if bus ();

  ssd_scan_arbiter #(
    .TICK_BITS    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: frame position plus latched frame contents
  logic [6:0]  c_dec [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  int          m_n;
  logic [31:0] m_data;
  logic [7:0]  m_en;
  logic [7:0]  m_dp;
  logic        m_gg;
  logic        m_gd;

  typedef struct {
    logic        gr;
    logic [31:0] gdat;
    logic        dr;
    logic [31:0] ddat;
    logic [7:0]  en;
    logic [7:0]  dpm;
    int          slot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        egg;
    logic        egd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic gr, input logic [31:0] gdat, input logic dr,
                        input logic [31:0] ddat, input logic [7:0] en, input logic [7:0] dpm);
    bus.game_req  = gr;
    bus.game_data = gdat;
    bus.dbg_req   = dr;
    bus.dbg_data  = ddat;
    bus.digit_en  = en;
    bus.dp_mask   = dpm;
  endtask

  // Expected pins after an edge, from the position in the frame before it.
  task automatic model_edge(output logic [18:0] exp);
    int         p;
    int         s;
    int         off;
    logic [7:0] an;
    logic [6:0] sg;
    logic       d;
    p = m_n % c_frame;
    if (p == 0) begin
      m_en = bus.digit_en;
      m_dp = bus.dp_mask;
      if (bus.dbg_req) begin
        m_data = bus.dbg_data; m_gd = 1'b1; m_gg = 1'b0;
      end else if (bus.game_req) begin
        m_data = bus.game_data; m_gd = 1'b0; m_gg = 1'b1;
      end else begin
        m_gd = 1'b0; m_gg = 1'b0;
      end
    end
    an = 8'hFF; sg = 7'h7F; d = 1'b1;
    if (p != 0) begin
      s   = (p - 1) / 16;
      off = (p - 1) % 16;
      if (off >= 2) begin
        sg = c_dec[m_data[s*4 +: 4]];
        if (m_en[s]) begin
          an = ~(8'd1 << s);
          d  = ~m_dp[s];
        end
      end
    end
    exp = {m_gg, m_gd, (p == c_frame - 1), an, sg, d};
    m_n++;
  endtask

  function automatic logic [18:0] pins();
    return {bus.grant_game, bus.grant_dbg, bus.frame_done, bus.an, bus.seg, bus.dp};
  endfunction

  task automatic tick(output logic [18:0] act);
    logic [18:0] e;
    @(posedge clk);
    model_edge(e);
    #1;
    act = pins();
    chk($sformatf("pins@%0d", m_n), {13'd0, act}, {13'd0, e});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_an",  {24'd0, bus.an},  32'hFF);
    chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
    chk("rst_dp",  {31'd0, bus.dp},  32'd1);
    chk("rst_gr",  {29'd0, bus.grant_game, bus.grant_dbg, bus.frame_done}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    m_n = 0; m_data = '0; m_en = '0; m_dp = '0; m_gg = 1'b0; m_gd = 1'b0;
  endtask

  // One full frame; optional mid-frame input change and random perturbation.
  task automatic run_frame(input int probe_k, input int chg_k, input logic [31:0] chg_gd,
                           input logic chg_dr, input bit rnd, output logic [18:0] probe);
    logic [18:0] a;
    int          fd;
    fd    = 0;
    probe = '0;
    for (int k = 0; k < c_frame; k++) begin
      tick(a);
      if (a[16]) fd++;
      if (k == probe_k) probe = a;
      if (k == chg_k) begin
        bus.game_data = chg_gd;
        bus.dbg_req   = chg_dr;
      end
      if (rnd && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.game_req  = ~bus.game_req;
          1: bus.dbg_req   = ~bus.dbg_req;
          2: bus.game_data = $urandom;
          3: bus.dbg_data  = $urandom;
          4: bus.digit_en  = 8'($urandom);
          default: bus.dp_mask = 8'($urandom);
        endcase
      end
    end
    chk("frame_done_count", fd, 1);
  endtask

  initial begin
    logic [18:0] pr;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    vecs[0] = '{1'b1, 32'h0000_0123, 1'b0, 32'h0, 8'hFF, 8'h01, 0, 8'hFE, 7'b0000110, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0123, 1'b0, 32'h0, 8'hFF, 8'h01, 1, 8'hFD, 7'b0010010, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0123, 1'b0, 32'h0, 8'hFF, 8'h01, 3, 8'hF7, 7'b0000001, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0123, 1'b1, 32'h89AB_CDEF, 8'hFF, 8'h01, 0, 8'hFE, 7'b0111000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h1234_5678, 1'b0, 32'h0, 8'h0F, 8'hFF, 5, 8'hFF, 7'b0000110, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 8'hFF, 8'h00, 4, 8'hEF, 7'b1001100, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_00AB, 1'b0, 32'h0, 8'hFF, 8'h00, 1, 8'hFD, 7'b0001000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 8'hFF, 8'h00, 0, 8'hFE, 7'b1100000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 8'hFF, 8'h00, 1, 8'hFD, 7'b0001000, 1'b1, 1'b0, 1'b0};

    set_in(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 8'h00);
    #1;
    apply_reset();

    // Table-driven frames; probe lands mid-drive of the chosen slot
    for (int v = 0; v < 9; v++) begin
      set_in(vecs[v].gr, vecs[v].gdat, vecs[v].dr, vecs[v].ddat, vecs[v].en, vecs[v].dpm);
      run_frame(1 + 16 * vecs[v].slot + 8, -1, 32'h0, 1'b0, 1'b0, pr);
      chk($sformatf("vec%0d_an", v),  {24'd0, pr[15:8]}, {24'd0, vecs[v].an});
      chk($sformatf("vec%0d_seg", v), {25'd0, pr[7:1]},  {25'd0, vecs[v].seg});
      chk($sformatf("vec%0d_dp", v),  {31'd0, pr[0]},    {31'd0, vecs[v].dp});
      chk($sformatf("vec%0d_gnt", v), {30'd0, pr[18:17]}, {30'd0, vecs[v].egg, vecs[v].egd});
    end

    // Debug drops its request mid-frame: grant held to the frame end
    set_in(1'b1, 32'h0000_0123, 1'b1, 32'h89AB_CDEF, 8'hFF, 8'h00);
    run_frame(128, 60, 32'h0000_0123, 1'b0, 1'b0, pr);
    chk("drop_gnt_end", {29'd0, pr[18:16]}, {29'd0, 3'b011});
    chk("drop_seg7", {25'd0, pr[7:1]}, {25'd0, 7'b0000000});
    run_frame(9, -1, 32'h0, 1'b0, 1'b0, pr);
    chk("next_gnt", {30'd0, pr[18:17]}, {30'd0, 2'b10});
    chk("next_seg0", {25'd0, pr[7:1]}, {25'd0, 7'b0000110});

    // Data change mid-frame takes effect only at the next frame
    set_in(1'b1, 32'h0000_0001, 1'b0, 32'h0, 8'hFF, 8'h00);
    run_frame(12, 5, 32'h0000_000F, 1'b0, 1'b0, pr);
    chk("hold_seg0", {25'd0, pr[7:1]}, {25'd0, 7'b1001111});
    run_frame(9, -1, 32'h0, 1'b0, 1'b0, pr);
    chk("new_seg0", {25'd0, pr[7:1]}, {25'd0, 7'b0111000});

    // Reset mid-DRIVE, then restart from LOAD
    for (int k = 0; k < 40; k++) tick(pr);
    #1;
    apply_reset();
    run_frame(0, -1, 32'h0, 1'b0, 1'b0, pr);
    chk("restart_load", {13'd0, pr}, {13'd0, 1'b1, 1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1});

    // Randomized frames with random mid-frame input disturbance
    for (int f = 0; f < 20; f++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
             8'($urandom), 8'($urandom));
      run_frame(-1, -1, 32'h0, 1'b0, 1'b1, pr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
